// File: rtl/load_store_queue_if.sv
// rtl/load_store_queue_if.sv - memory controller bus between the load/store queue and memory
interface load_store_queue_if #(
   parameter int XLEN = 32
);
   logic            mem_signal;
   logic            mem_wr;
   logic [1:0]      mem_len;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_dout;
   logic [XLEN-1:0] mem_din;
   logic            mem_done;

   modport master (
      output mem_signal, mem_wr, mem_len, mem_addr, mem_dout,
      input  mem_din, mem_done
   );

   modport slave (
      input  mem_signal, mem_wr, mem_len, mem_addr, mem_dout,
      output mem_din, mem_done
   );
endinterface

// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order load/store queue with CDB wakeup; LSQ_LOAD_BYPASS_EN lets loads pass older stores
module load_store_queue #(
   parameter int              XLEN      = 32,
   parameter int              LSQ_WIDTH = 4,
   parameter int              ROB_WIDTH = 4,
   parameter logic [XLEN-1:0] IO_BASE   = 32'h0003_0000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_signal,
   input  logic                 issue_signal,
   input  logic                 issue_wr,
   input  logic [1:0]           issue_len,
   input  logic                 issue_signed,
   input  logic [XLEN-1:0]      issue_base,
   input  logic [ROB_WIDTH-1:0] issue_base_tag,
   input  logic                 issue_base_valid,
   input  logic [XLEN-1:0]      issue_data,
   input  logic [ROB_WIDTH-1:0] issue_data_tag,
   input  logic                 issue_data_valid,
   input  logic [11:0]          issue_imm,
   input  logic [ROB_WIDTH-1:0] issue_rob_tag,
   input  logic                 commit_signal,
   input  logic [ROB_WIDTH-1:0] commit_tag,
   input  logic                 cdb_signal,
   input  logic [XLEN-1:0]      cdb_value,
   input  logic [ROB_WIDTH-1:0] cdb_tag,
   load_store_queue_if.master   mem,
   output logic                 lsq_signal,
   output logic [XLEN-1:0]      lsq_value,
   output logic [ROB_WIDTH-1:0] lsq_tag,
   output logic                 full
);
   localparam int LSQ_SIZE = 2 ** LSQ_WIDTH;
`ifdef LSQ_LOAD_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif
   localparam logic [LSQ_WIDTH:0]   CNT_ONE = (LSQ_WIDTH+1)'(1);
   localparam logic [LSQ_WIDTH-1:0] IDX_ONE = LSQ_WIDTH'(1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   typedef struct packed {
      logic                 busy;
      logic                 wr;
      logic                 sgn;
      logic                 base_valid;
      logic                 data_valid;
      logic                 addr_valid;
      logic                 committed;
      logic                 done;
      logic [1:0]           len;
      logic [XLEN-1:0]      base;
      logic [XLEN-1:0]      data;
      logic [XLEN-1:0]      addr;
      logic [ROB_WIDTH-1:0] base_tag;
      logic [ROB_WIDTH-1:0] data_tag;
      logic [ROB_WIDTH-1:0] rob_tag;
      logic [11:0]          imm;
   } entry_t;

   entry_t                 ent_q [LSQ_SIZE];
   entry_t                 ent_d [LSQ_SIZE];
   logic [LSQ_WIDTH-1:0]   front_q, front_d, rear_q, rear_d, cur_q, cur_d;
   logic [LSQ_WIDTH:0]     count_q, count_d;
   state_t                 state_q, state_d;
   logic                   mem_signal_q, mem_signal_d, mem_wr_q, mem_wr_d;
   logic [1:0]             mem_len_q, mem_len_d;
   logic [XLEN-1:0]        mem_addr_q, mem_addr_d, mem_dout_q, mem_dout_d;
   logic                   lsq_signal_q, lsq_signal_d;
   logic [XLEN-1:0]        lsq_value_q, lsq_value_d;
   logic [ROB_WIDTH-1:0]   lsq_tag_q, lsq_tag_d;
   logic                   sel_valid;
   logic [LSQ_WIDTH-1:0]   sel_idx;
   logic                   issue_ok, retire;

   function automatic logic [XLEN-1:0] extend(logic [XLEN-1:0] din, logic [1:0] len, logic sgn);
      case (len)
         2'b00:   extend = {{(XLEN-8){sgn & din[7]}}, din[7:0]};
         2'b01:   extend = {{(XLEN-16){sgn & din[15]}}, din[15:0]};
         default: extend = din;
      endcase
   endfunction

   function automatic logic mem_ready(entry_t e);
      mem_ready = e.busy && !e.done && e.addr_valid && (!e.wr || (e.data_valid && e.committed));
   endfunction

   assign full       = (count_q == (LSQ_WIDTH+1)'(LSQ_SIZE));
   assign issue_ok   = issue_signal && !full && !clear_signal;
   assign retire     = (count_q != '0) && (!ent_q[front_q].busy || ent_q[front_q].done) && !clear_signal;

   assign mem.mem_signal = mem_signal_q;
   assign mem.mem_wr     = mem_wr_q;
   assign mem.mem_len    = mem_len_q;
   assign mem.mem_addr   = mem_addr_q;
   assign mem.mem_dout   = mem_dout_q;
   assign lsq_signal     = lsq_signal_q;
   assign lsq_value      = lsq_value_q;
   assign lsq_tag        = lsq_tag_q;

   // Next-state for entries, pointers and the memory FSM: wakeup, select, complete, retire, issue, flush
   always_comb begin
      logic [LSQ_WIDTH-1:0] idx;
      logic [LSQ_WIDTH-1:0] jdx;
      logic                 blocked;
      logic                 found;
      int                   last;
      entry_t               nw;

      for (int i = 0; i < LSQ_SIZE; i++) ent_d[i] = ent_q[i];
      front_d      = front_q;
      rear_d       = rear_q;
      count_d      = count_q;
      cur_d        = cur_q;
      state_d      = state_q;
      mem_signal_d = mem_signal_q;
      mem_wr_d     = mem_wr_q;
      mem_len_d    = mem_len_q;
      mem_addr_d   = mem_addr_q;
      mem_dout_d   = mem_dout_q;
      lsq_signal_d = 1'b0;
      lsq_value_d  = lsq_value_q;
      lsq_tag_d    = lsq_tag_q;
      sel_valid    = 1'b0;
      sel_idx      = front_q;
      idx          = '0;
      jdx          = '0;
      blocked      = 1'b0;
      found        = 1'b0;
      last         = 0;
      nw           = '0;

      // operand wakeup from both broadcast buses, address generation, commit marking
      for (int i = 0; i < LSQ_SIZE; i++) begin
         if (ent_q[i].busy) begin
            if (!ent_q[i].base_valid) begin
               if (cdb_signal && ent_q[i].base_tag == cdb_tag) begin
                  ent_d[i].base = cdb_value;  ent_d[i].base_valid = 1'b1;
               end else if (lsq_signal_q && ent_q[i].base_tag == lsq_tag_q) begin
                  ent_d[i].base = lsq_value_q; ent_d[i].base_valid = 1'b1;
               end
            end
            if (!ent_q[i].data_valid) begin
               if (cdb_signal && ent_q[i].data_tag == cdb_tag) begin
                  ent_d[i].data = cdb_value;  ent_d[i].data_valid = 1'b1;
               end else if (lsq_signal_q && ent_q[i].data_tag == lsq_tag_q) begin
                  ent_d[i].data = lsq_value_q; ent_d[i].data_valid = 1'b1;
               end
            end
            if (ent_q[i].base_valid && !ent_q[i].addr_valid) begin
               ent_d[i].addr       = ent_q[i].base + {{(XLEN-12){ent_q[i].imm[11]}}, ent_q[i].imm};
               ent_d[i].addr_valid = 1'b1;
            end
            if (commit_signal && ent_q[i].wr && ent_q[i].rob_tag == commit_tag)
               ent_d[i].committed = 1'b1;
         end
      end

      // pick the head, or with bypass the oldest load clear of every older store
      for (int i = 0; i < LSQ_SIZE; i++) begin
         idx = front_q + LSQ_WIDTH'(i);
         if (!sel_valid && (LSQ_WIDTH+1)'(i) < count_q) begin
            if (i == 0) begin
               if (mem_ready(ent_q[idx])) begin
                  sel_valid = 1'b1;
                  sel_idx   = idx;
               end
            end else if (BYPASS_EN && ent_q[idx].busy && !ent_q[idx].wr && !ent_q[idx].done &&
                         ent_q[idx].addr_valid && ent_q[idx].addr < IO_BASE) begin
               blocked = 1'b0;
               for (int j = 0; j < LSQ_SIZE; j++) begin
                  jdx = front_q + LSQ_WIDTH'(j);
                  if (j < i && ent_q[jdx].busy && ent_q[jdx].wr &&
                      (!ent_q[jdx].addr_valid || ent_q[jdx].addr[XLEN-1:2] == ent_q[idx].addr[XLEN-1:2]))
                     blocked = 1'b1;
               end
               if (!blocked) begin
                  sel_valid = 1'b1;
                  sel_idx   = idx;
               end
            end
         end
      end

      // memory FSM; an in-flight load is abandoned on flush, an in-flight store always finishes
      case (state_q)
         S_IDLE: begin
            if (sel_valid && !clear_signal) begin
               state_d      = S_WAIT;
               cur_d        = sel_idx;
               mem_signal_d = 1'b1;
               mem_wr_d     = ent_q[sel_idx].wr;
               mem_len_d    = ent_q[sel_idx].len;
               mem_addr_d   = ent_q[sel_idx].addr;
               mem_dout_d   = ent_q[sel_idx].data;
            end
         end
         S_WAIT: begin
            if (clear_signal && !mem_wr_q) begin
               state_d      = S_IDLE;
               mem_signal_d = 1'b0;
            end else if (mem.mem_done) begin
               state_d           = S_IDLE;
               mem_signal_d      = 1'b0;
               ent_d[cur_q].done = 1'b1;
               if (!mem_wr_q) begin
                  lsq_signal_d = 1'b1;
                  lsq_value_d  = extend(mem.mem_din, ent_q[cur_q].len, ent_q[cur_q].sgn);
                  lsq_tag_d    = ent_q[cur_q].rob_tag;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         ent_d[front_q] = '0;
         front_d        = front_q + IDX_ONE;
      end

      if (issue_ok) begin
         nw.busy       = 1'b1;
         nw.wr         = issue_wr;
         nw.sgn        = issue_signed;
         nw.len        = issue_len;
         nw.imm        = issue_imm;
         nw.rob_tag    = issue_rob_tag;
         nw.base_tag   = issue_base_tag;
         nw.data_tag   = issue_data_tag;
         nw.base       = issue_base;
         nw.base_valid = issue_base_valid;
         nw.data       = issue_data;
         nw.data_valid = issue_data_valid;
         if (!issue_base_valid && cdb_signal && issue_base_tag == cdb_tag) begin
            nw.base = cdb_value;   nw.base_valid = 1'b1;
         end else if (!issue_base_valid && lsq_signal_q && issue_base_tag == lsq_tag_q) begin
            nw.base = lsq_value_q; nw.base_valid = 1'b1;
         end
         if (!issue_data_valid && cdb_signal && issue_data_tag == cdb_tag) begin
            nw.data = cdb_value;   nw.data_valid = 1'b1;
         end else if (!issue_data_valid && lsq_signal_q && issue_data_tag == lsq_tag_q) begin
            nw.data = lsq_value_q; nw.data_valid = 1'b1;
         end
         ent_d[rear_q] = nw;
         rear_d        = rear_q + IDX_ONE;
      end

      if (issue_ok && !retire)      count_d = count_q + CNT_ONE;
      else if (!issue_ok && retire) count_d = count_q - CNT_ONE;

      // flush keeps only committed stores; the queue ends just after the youngest of them
      if (clear_signal) begin
         for (int i = 0; i < LSQ_SIZE; i++) begin
            idx = front_q + LSQ_WIDTH'(i);
            if ((LSQ_WIDTH+1)'(i) < count_q && ent_d[idx].busy && ent_d[idx].wr && ent_d[idx].committed) begin
               found = 1'b1;
               last  = i;
            end
         end
         for (int i = 0; i < LSQ_SIZE; i++)
            if (!(ent_d[i].busy && ent_d[i].committed)) ent_d[i] = '0;
         rear_d  = found ? front_q + LSQ_WIDTH'(last + 1) : front_q;
         count_d = found ? (LSQ_WIDTH+1)'(last + 1) : '0;
      end
   end

   // State registers; everything holds while rdy_in is low
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < LSQ_SIZE; i++) ent_q[i] <= '0;
         front_q      <= '0;
         rear_q       <= '0;
         count_q      <= '0;
         cur_q        <= '0;
         state_q      <= S_IDLE;
         mem_signal_q <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_len_q    <= '0;
         mem_addr_q   <= '0;
         mem_dout_q   <= '0;
         lsq_signal_q <= 1'b0;
         lsq_value_q  <= '0;
         lsq_tag_q    <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < LSQ_SIZE; i++) ent_q[i] <= ent_d[i];
         front_q      <= front_d;
         rear_q       <= rear_d;
         count_q      <= count_d;
         cur_q        <= cur_d;
         state_q      <= state_d;
         mem_signal_q <= mem_signal_d;
         mem_wr_q     <= mem_wr_d;
         mem_len_q    <= mem_len_d;
         mem_addr_q   <= mem_addr_d;
         mem_dout_q   <= mem_dout_d;
         lsq_signal_q <= lsq_signal_d;
         lsq_value_q  <= lsq_value_d;
         lsq_tag_q    <= lsq_tag_d;
      end
   end
endmodule

// File: tb/tb_load_store_queue.sv
// tb/tb_load_store_queue.sv - directed self-checking bench for load_store_queue
module tb_load_store_queue;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_signal;
   logic        issue_signal, issue_wr, issue_signed, issue_base_valid, issue_data_valid;
   logic [1:0]  issue_len;
   logic [31:0] issue_base, issue_data, cdb_value, lsq_value;
   logic [3:0]  issue_base_tag, issue_data_tag, issue_rob_tag, commit_tag, cdb_tag, lsq_tag;
   logic [11:0] issue_imm;
   logic        commit_signal, cdb_signal, lsq_signal, full;
   int          total = 0;
   int          bad = 0;

   load_store_queue_if #(.XLEN(32)) mem_bus ();

   load_store_queue dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
      .issue_signal(issue_signal), .issue_wr(issue_wr), .issue_len(issue_len),
      .issue_signed(issue_signed), .issue_base(issue_base), .issue_base_tag(issue_base_tag),
      .issue_base_valid(issue_base_valid), .issue_data(issue_data), .issue_data_tag(issue_data_tag),
      .issue_data_valid(issue_data_valid), .issue_imm(issue_imm), .issue_rob_tag(issue_rob_tag),
      .commit_signal(commit_signal), .commit_tag(commit_tag), .cdb_signal(cdb_signal),
      .cdb_value(cdb_value), .cdb_tag(cdb_tag), .mem(mem_bus), .lsq_signal(lsq_signal),
      .lsq_value(lsq_value), .lsq_tag(lsq_tag), .full(full)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [1:0] len, input logic sgn,
                        input logic [31:0] base, input logic bv, input logic [3:0] btag,
                        input logic [31:0] data, input logic dv, input logic [3:0] dtag,
                        input logic [11:0] imm, input logic [3:0] rob);
      issue_wr = wr; issue_len = len; issue_signed = sgn;
      issue_base = base; issue_base_valid = bv; issue_base_tag = btag;
      issue_data = data; issue_data_valid = dv; issue_data_tag = dtag;
      issue_imm = imm; issue_rob_tag = rob; issue_signal = 1'b1;
      step();
      issue_signal = 1'b0;
   endtask

   task automatic wait_mem(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (mem_bus.mem_signal) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic respond(input logic [31:0] din);
      mem_bus.mem_din = din; mem_bus.mem_done = 1'b1;
      step();
      mem_bus.mem_done = 1'b0; mem_bus.mem_din = '0;
   endtask

   task automatic watch(input int n, output int seen);
      seen = 0;
      for (int i = 0; i < n; i++) begin
         if (mem_bus.mem_signal || lsq_signal) seen++;
         step();
      end
   endtask

   task automatic do_clear();
      clear_signal = 1'b1;
      step();
      clear_signal = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] tag);
      commit_signal = 1'b1; commit_tag = tag;
      step();
      commit_signal = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 0; issue_signal = 0; commit_signal = 0;
      cdb_signal = 0; cdb_value = 0; cdb_tag = 0; commit_tag = 0;
      issue_wr = 0; issue_len = 0; issue_signed = 0; issue_base = 0; issue_base_valid = 0;
      issue_base_tag = 0; issue_data = 0; issue_data_valid = 0; issue_data_tag = 0;
      issue_imm = 0; issue_rob_tag = 0; mem_bus.mem_din = 0; mem_bus.mem_done = 0;
      step(); step();
      total++; if (mem_bus.mem_signal !== 1'b0) begin bad++; $display("FAIL reset_mem_signal got=%b exp=0", mem_bus.mem_signal); end
      total++; if (mem_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_bus.mem_addr); end
      total++; if (lsq_signal !== 1'b0) begin bad++; $display("FAIL reset_lsq_signal got=%b exp=0", lsq_signal); end
      total++; if (lsq_value !== 32'h0) begin bad++; $display("FAIL reset_lsq_value got=%h exp=0", lsq_value); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      rst_in = 1'b0;
      step();
   endtask

   task automatic test_word_load();
      bit ok;
      issue(0, 2'b10, 0, 32'h1000, 1, 0, 0, 1, 0, 12'h004, 4'd1);
      wait_mem(ok);
      total++; if (!ok) begin bad++; $display("FAIL lw_request got=none exp=request"); end
      total++; if (mem_bus.mem_addr !== 32'h1004) begin bad++; $display("FAIL lw_addr got=%h exp=00001004", mem_bus.mem_addr); end
      total++; if (mem_bus.mem_len !== 2'b10 || mem_bus.mem_wr !== 1'b0) begin bad++; $display("FAIL lw_len_wr got=%b/%b exp=10/0", mem_bus.mem_len, mem_bus.mem_wr); end
      respond(32'hDEAD_BEEF);
      total++; if (lsq_signal !== 1'b1 || lsq_value !== 32'hDEAD_BEEF || lsq_tag !== 4'd1) begin bad++; $display("FAIL lw_result got=%b/%h/%0d exp=1/deadbeef/1", lsq_signal, lsq_value, lsq_tag); end
      step();
      total++; if (lsq_signal !== 1'b0 || mem_bus.mem_signal !== 1'b0) begin bad++; $display("FAIL lw_one_cycle got=%b/%b exp=0/0", lsq_signal, mem_bus.mem_signal); end
   endtask

   task automatic test_narrow_loads();
      bit ok;
      issue(0, 2'b00, 1, 32'h2000, 1, 0, 0, 1, 0, 12'h000, 4'd2);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h2000 || mem_bus.mem_len !== 2'b00) begin bad++; $display("FAIL lb_request got=%b/%h/%b exp=1/00002000/00", ok, mem_bus.mem_addr, mem_bus.mem_len); end
      respond(32'h0000_0080);
      total++; if (lsq_signal !== 1'b1 || lsq_value !== 32'hFFFF_FF80 || lsq_tag !== 4'd2) begin bad++; $display("FAIL lb_signed got=%b/%h/%0d exp=1/ffffff80/2", lsq_signal, lsq_value, lsq_tag); end
      issue(0, 2'b00, 0, 32'h2000, 1, 0, 0, 1, 0, 12'h000, 4'd3);
      wait_mem(ok);
      respond(32'h0000_0080);
      total++; if (!ok || lsq_signal !== 1'b1 || lsq_value !== 32'h0000_0080 || lsq_tag !== 4'd3) begin bad++; $display("FAIL lbu got=%b/%h/%0d exp=1/00000080/3", lsq_signal, lsq_value, lsq_tag); end
      issue(0, 2'b01, 1, 32'h2000, 1, 0, 0, 1, 0, 12'hFFE, 4'd4);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h1FFE || mem_bus.mem_len !== 2'b01) begin bad++; $display("FAIL lh_neg_imm_addr got=%b/%h/%b exp=1/00001ffe/01", ok, mem_bus.mem_addr, mem_bus.mem_len); end
      respond(32'h0000_8001);
      total++; if (lsq_value !== 32'hFFFF_8001 || lsq_tag !== 4'd4) begin bad++; $display("FAIL lh_signed got=%h/%0d exp=ffff8001/4", lsq_value, lsq_tag); end
      step();
   endtask

   task automatic test_store_wakeup();
      bit ok;
      int seen;
      issue(1, 2'b10, 0, 32'h0, 0, 4'd3, 32'h0, 0, 4'd5, 12'h010, 4'd6);
      cdb_signal = 1; cdb_tag = 4'd3; cdb_value = 32'h100;
      step();
      cdb_tag = 4'd5; cdb_value = 32'h55;
      step();
      cdb_signal = 0;
      watch(6, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL sw_waits_commit got=%0d exp=0", seen); end
      do_commit(4'd6);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_wr !== 1'b1) begin bad++; $display("FAIL sw_request got=%b/%b exp=1/1", ok, mem_bus.mem_wr); end
      total++; if (mem_bus.mem_addr !== 32'h110 || mem_bus.mem_dout !== 32'h55) begin bad++; $display("FAIL sw_addr_data got=%h/%h exp=00000110/00000055", mem_bus.mem_addr, mem_bus.mem_dout); end
      respond(32'h0);
      total++; if (lsq_signal !== 1'b0 || mem_bus.mem_signal !== 1'b0) begin bad++; $display("FAIL sw_no_broadcast got=%b/%b exp=0/0", lsq_signal, mem_bus.mem_signal); end
      step();
   endtask

   task automatic test_issue_capture();
      bit ok;
      cdb_signal = 1; cdb_tag = 4'd7; cdb_value = 32'h3000;
      issue(0, 2'b10, 0, 32'h0, 0, 4'd7, 0, 1, 0, 12'h008, 4'd8);
      cdb_signal = 0;
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h3008) begin bad++; $display("FAIL same_cycle_capture got=%b/%h exp=1/00003008", ok, mem_bus.mem_addr); end
      respond(32'h1234);
      total++; if (lsq_value !== 32'h1234 || lsq_tag !== 4'd8) begin bad++; $display("FAIL capture_result got=%h/%0d exp=00001234/8", lsq_value, lsq_tag); end
      step();
   endtask

   task automatic test_full();
      bit ok;
      int seen;
      for (int i = 0; i < 16; i++) begin
         issue(1, 2'b10, 0, 32'h4000 + 32'(i * 16), 1, 0, 32'(i), 1, 0, 12'h000, 4'(i));
         if (i == 14) begin
            total++; if (full !== 1'b0) begin bad++; $display("FAIL full_at_15 got=%b exp=0", full); end
         end
      end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL full_at_16 got=%b exp=1", full); end
      issue(1, 2'b10, 0, 32'hBAD0, 1, 0, 32'hBAD, 1, 0, 12'h000, 4'd0);
      total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after_17th got=%b exp=1", full); end
      do_commit(4'd0);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h4000 || mem_bus.mem_dout !== 32'h0) begin bad++; $display("FAIL full_head_store got=%b/%h/%h exp=1/00004000/00000000", ok, mem_bus.mem_addr, mem_bus.mem_dout); end
      respond(32'h0);
      total++; if (full !== 1'b1) begin bad++; $display("FAIL full_before_retire got=%b exp=1", full); end
      step();
      total++; if (full !== 1'b0) begin bad++; $display("FAIL full_after_retire got=%b exp=0", full); end
      do_clear();
      watch(6, seen);
      total++; if (seen !== 0 || full !== 1'b0) begin bad++; $display("FAIL flush_uncommitted got=%0d/%b exp=0/0", seen, full); end
   endtask

   task automatic test_clear_committed();
      bit ok;
      int seen;
      issue(1, 2'b10, 0, 32'h500, 1, 0, 32'h77, 1, 0, 12'h000, 4'd1);
      issue(0, 2'b10, 0, 32'h600, 1, 0, 0, 1, 0, 12'h000, 4'd2);
      issue(0, 2'b10, 0, 32'h640, 1, 0, 0, 1, 0, 12'h000, 4'd3);
      do_commit(4'd1);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_wr !== 1'b1 || mem_bus.mem_addr !== 32'h500) begin bad++; $display("FAIL clr_store_request got=%b/%b/%h exp=1/1/00000500", ok, mem_bus.mem_wr, mem_bus.mem_addr); end
      do_clear();
      total++; if (mem_bus.mem_signal !== 1'b1 || mem_bus.mem_dout !== 32'h77) begin bad++; $display("FAIL clr_store_held got=%b/%h exp=1/00000077", mem_bus.mem_signal, mem_bus.mem_dout); end
      respond(32'h0);
      total++; if (mem_bus.mem_signal !== 1'b0) begin bad++; $display("FAIL clr_store_done got=%b exp=0", mem_bus.mem_signal); end
      watch(8, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL clr_loads_dropped got=%0d exp=0", seen); end
      issue(0, 2'b10, 0, 32'h700, 1, 0, 0, 1, 0, 12'h000, 4'd4);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h700) begin bad++; $display("FAIL clr_next_load got=%b/%h exp=1/00000700", ok, mem_bus.mem_addr); end
      respond(32'hCAFE_0000);
      total++; if (lsq_signal !== 1'b1 || lsq_value !== 32'hCAFE_0000 || lsq_tag !== 4'd4) begin bad++; $display("FAIL clr_next_result got=%b/%h/%0d exp=1/cafe0000/4", lsq_signal, lsq_value, lsq_tag); end
      step();
   endtask

   task automatic test_clear_inflight_load();
      bit ok;
      issue(0, 2'b10, 0, 32'h800, 1, 0, 0, 1, 0, 12'h000, 4'd5);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h800) begin bad++; $display("FAIL inflight_request got=%b/%h exp=1/00000800", ok, mem_bus.mem_addr); end
      do_clear();
      total++; if (mem_bus.mem_signal !== 1'b0) begin bad++; $display("FAIL inflight_dropped got=%b exp=0", mem_bus.mem_signal); end
      respond(32'h1111);
      total++; if (lsq_signal !== 1'b0) begin bad++; $display("FAIL late_done_ignored got=%b exp=0", lsq_signal); end
      step();
      total++; if (lsq_signal !== 1'b0 || mem_bus.mem_signal !== 1'b0) begin bad++; $display("FAIL late_done_quiet got=%b/%b exp=0/0", lsq_signal, mem_bus.mem_signal); end
      issue(0, 2'b10, 0, 32'h900, 1, 0, 0, 1, 0, 12'h000, 4'd6);
      wait_mem(ok);
      respond(32'h2222);
      total++; if (!ok || lsq_value !== 32'h2222 || lsq_tag !== 4'd6) begin bad++; $display("FAIL after_flush_load got=%b/%h/%0d exp=1/00002222/6", ok, lsq_value, lsq_tag); end
      step();
   endtask

   task automatic test_stall();
      int seen;
      rdy_in = 1'b0;
      issue(0, 2'b10, 0, 32'hA00, 1, 0, 0, 1, 0, 12'h000, 4'd7);
      rdy_in = 1'b1;
      watch(6, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL stalled_issue_ignored got=%0d exp=0", seen); end
   endtask

   task automatic test_ordering();
      int seen;
`ifdef LSQ_LOAD_BYPASS_EN
      bit ok;
      issue(1, 2'b10, 0, 32'h100, 1, 0, 32'h1, 1, 0, 12'h000, 4'd9);
      issue(0, 2'b10, 0, 32'h200, 1, 0, 0, 1, 0, 12'h000, 4'd10);
      wait_mem(ok);
      total++; if (!ok || mem_bus.mem_addr !== 32'h200 || mem_bus.mem_wr !== 1'b0) begin bad++; $display("FAIL bypass_load got=%b/%h/%b exp=1/00000200/0", ok, mem_bus.mem_addr, mem_bus.mem_wr); end
      respond(32'hABCD);
      total++; if (lsq_signal !== 1'b1 || lsq_tag !== 4'd10) begin bad++; $display("FAIL bypass_result got=%b/%0d exp=1/10", lsq_signal, lsq_tag); end
      do_clear();
      issue(1, 2'b10, 0, 32'h100, 1, 0, 32'h1, 1, 0, 12'h000, 4'd11);
      issue(0, 2'b10, 0, 32'h100, 1, 0, 0, 1, 0, 12'h000, 4'd12);
      watch(8, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL bypass_same_word_waits got=%0d exp=0", seen); end
      do_clear();
      issue(1, 2'b10, 0, 32'h100, 1, 0, 32'h1, 1, 0, 12'h000, 4'd13);
      issue(0, 2'b10, 0, 32'h30000, 1, 0, 0, 1, 0, 12'h000, 4'd14);
      watch(8, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL bypass_io_waits got=%0d exp=0", seen); end
      do_clear();
`else
      issue(1, 2'b10, 0, 32'h100, 1, 0, 32'h1, 1, 0, 12'h000, 4'd9);
      issue(0, 2'b10, 0, 32'h200, 1, 0, 0, 1, 0, 12'h000, 4'd10);
      watch(8, seen);
      total++; if (seen !== 0) begin bad++; $display("FAIL in_order_load_waits got=%0d exp=0", seen); end
      do_clear();
`endif
      step();
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_narrow_loads();
      test_store_wakeup();
      test_issue_capture();
      test_full();
      test_clear_committed();
      test_clear_inflight_load();
      test_stall();
      test_ordering();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
